cal_mac_int8_x2_acc: RTL and testbench

Packed dual-MAC for conv layers: one DSP48E2-style slice computes a*c and b*c per cycle, with one shared activation c and two weights a/b in the pre-adder packing.
- Unpacks both products with sign-borrow correction.
- Accumulates each product stream over a variable-length group delimited by in_last.
- Emits both sums with a one-cycle valid strobe.
- Sits between weight/activation buffers and the requantisation stage.

---
 rtl/cal_mac_int8_x2_acc_pkg.sv | 39 +++
 rtl/cal_mac_int8_x2_acc_if.sv | 44 ++++
 rtl/cal_mac_int8_x2_acc_mul.sv | 82 ++++++++
 rtl/cal_mac_int8_x2_acc.sv | 136 +++++++++++++
 tb/tb_cal_mac_int8_x2_acc.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cal_mac_int8_x2_acc_pkg.sv
// cal_dsp_pkg: shared constants and helpers for the packed dual-MAC.
//
// Contents:
//   PACK_SHIFT  bit offset of weight a inside the 27-bit A port
//   A_W/D_W/B_W/P_W  DSP slice port widths (pre-adder, multiplier, product)
//   PIPE_LAT    input-to-output latency of cal_mac_int8_x2_acc in clk edges
//   unpack_x2() splits a packed 45-bit product into (a*c, b*c)
package cal_dsp_pkg;

    localparam int PACK_SHIFT = 18;
    localparam int A_W        = 27;
    localparam int D_W        = 27;
    localparam int B_W        = 18;
    localparam int P_W        = 45;
    localparam int PIPE_LAT   = 6;

    // Both halves are returned sign-extended to the full product width.
    typedef struct packed {
        logic signed [P_W-1:0] ac;
        logic signed [P_W-1:0] bc;
    } prod_pair_t;

    // The product is M = (a*c << PACK_SHIFT) + b*c. When b*c is negative it
    // borrows one from the upper field; the borrow shows up as bit
    // PACK_SHIFT-1 being set (|b*c| is far below 2^(PACK_SHIFT-1)), so adding
    // that bit back restores a*c exactly.
    function automatic prod_pair_t unpack_x2(input logic [P_W-1:0] m, input int dw);
        prod_pair_t      r;
        int              sh;
        logic [P_W-1:0]  hi_field;
        sh       = P_W - 2 * dw;
        r.bc     = $signed(m << sh) >>> sh;
        hi_field = m >> PACK_SHIFT;
        r.ac     = ($signed(hi_field << sh) >>> sh)
                 + $signed({{(P_W-1){1'b0}}, m[PACK_SHIFT-1]});
        return r;
    endfunction

endpackage

// File: rtl/cal_mac_int8_x2_acc_if.sv
// cal_mac_int8_x2_acc_if: sample input and group-sum output bundle of the
// packed dual-MAC.
//
// Handshake: in_valid qualifies in_a/in_b/in_c/in_last in the cycle it is
// high; there is no ready, every valid sample is consumed. out_valid is a
// one-cycle strobe with no backpressure; out_ac/out_bc (and out_sat when
// CAL_MAC_SAT_EN is defined) hold until the next strobe.
//
// Modports:
//   master  drives the samples, receives the sums (upstream/downstream side)
//   slave   the MAC itself
interface cal_mac_int8_x2_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    logic                     in_valid;
    logic                     in_last;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic signed [DATA_W-1:0] in_c;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_ac;
    logic signed [ACC_W-1:0]  out_bc;
`ifdef CAL_MAC_SAT_EN
    logic                     out_sat;
`endif

    modport master (
        output in_valid, in_last, in_a, in_b, in_c,
        input  out_valid, out_ac, out_bc
`ifdef CAL_MAC_SAT_EN
        , input out_sat
`endif
    );

    modport slave (
        input  in_valid, in_last, in_a, in_b, in_c,
        output out_valid, out_ac, out_bc
`ifdef CAL_MAC_SAT_EN
        , output out_sat
`endif
    );

endinterface

// File: rtl/cal_mac_int8_x2_acc_mul.sv
// cal_mul_pack_x2: stages S1..S5 of the dual-MAC. Packs a/b/c onto one
// pre-adder + multiplier, then unpacks a*c and b*c. Pure pipeline; valid and
// last travel alongside the data, only the valid bits are reset.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_last        sample qualifier / group end
//   in_a, in_b, in_c         signed weights and shared activation
//   out_valid, out_last      S5 qualifier / group end
//   out_ac, out_bc           S5 products, sign-extended to ACC_W
module cal_mul_pack_x2
    import cal_dsp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    input  logic signed [DATA_W-1:0] in_c,
    output logic                     out_valid,
    output logic                     out_last,
    output logic signed [ACC_W-1:0]  out_ac,
    output logic signed [ACC_W-1:0]  out_bc
);

    // Bit i of v_q/l_q belongs to stage S(i+1).
    logic [4:0]            v_q;
    logic [4:0]            l_q;

    logic signed [A_W-1:0] a_q;
    logic signed [D_W-1:0] d_q;
    logic signed [B_W-1:0] b1_q;
    logic signed [A_W-1:0] p_q;
    logic signed [B_W-1:0] b2_q;
    logic signed [P_W-1:0] m3_q;
    logic signed [P_W-1:0] m4_q;
    logic signed [P_W-1:0] p_ext;
    logic signed [P_W-1:0] b_ext;
    prod_pair_t            pair;
    logic                  unused_hi;

    assign p_ext = $signed({{(P_W-A_W){p_q[A_W-1]}}, p_q});
    assign b_ext = $signed({{(P_W-B_W){b2_q[B_W-1]}}, b2_q});
    assign pair  = unpack_x2(m4_q, DATA_W);

    // Upper product bits above ACC_W are pure sign extension.
    assign unused_hi = ^{pair.ac[P_W-1:ACC_W], pair.bc[P_W-1:ACC_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q <= {v_q[3:0], in_valid};
            l_q <= {l_q[3:0], in_valid & in_last};
        end
    end

    always_ff @(posedge clk) begin
        // S1: pack. a sits at PACK_SHIFT with zeros below; b and c sign-extended.
        a_q  <= {{(A_W-PACK_SHIFT-DATA_W){in_a[DATA_W-1]}}, in_a, {PACK_SHIFT{1'b0}}};
        d_q  <= {{(D_W-DATA_W){in_b[DATA_W-1]}}, in_b};
        b1_q <= {{(B_W-DATA_W){in_c[DATA_W-1]}}, in_c};
        // S2: pre-add; c delayed to stay aligned with P.
        p_q  <= a_q + d_q;
        b2_q <= b1_q;
        // S3/S4: multiply, then a second product register.
        m3_q <= p_ext * b_ext;
        m4_q <= m3_q;
        // S5: unpack with borrow correction.
        out_ac <= pair.ac[ACC_W-1:0];
        out_bc <= pair.bc[ACC_W-1:0];
    end

    assign out_valid = v_q[4];
    assign out_last  = l_q[4];

endmodule

// File: rtl/cal_mac_int8_x2_acc.sv
// cal_mac_int8_x2_acc: packed dual-MAC with group accumulation. Computes
// a*c and b*c per sample on one multiplier, sums each stream over a group
// closed by in_last and strobes both sums out PIPE_LAT edges after the last
// sample is accepted.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   cal_mac_int8_x2_acc_if.slave (in_valid/in_last/in_a/in_b/in_c in,
//         out_valid/out_ac/out_bc[/out_sat] out)
//
// Build option: CAL_MAC_SAT_EN makes each accumulate saturate and adds the
// sticky out_sat flag; without it the sums wrap modulo 2^ACC_W.
module cal_mac_int8_x2_acc
    import cal_dsp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    cal_mac_int8_x2_acc_if.slave  bus
);

    logic                    s5_valid;
    logic                    s5_last;
    logic signed [ACC_W-1:0] s5_ac;
    logic signed [ACC_W-1:0] s5_bc;

    cal_mul_pack_x2 #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_last   (bus.in_last),
        .in_a      (bus.in_a),
        .in_b      (bus.in_b),
        .in_c      (bus.in_c),
        .out_valid (s5_valid),
        .out_last  (s5_last),
        .out_ac    (s5_ac),
        .out_bc    (s5_bc)
    );

    // grp_open is 0 when the next valid sample starts a new group (after
    // reset or after a last); that sample loads instead of adding.
    logic                    grp_open;
    logic signed [ACC_W-1:0] acc_ac;
    logic signed [ACC_W-1:0] acc_bc;
    logic signed [ACC_W-1:0] nxt_ac;
    logic signed [ACC_W-1:0] nxt_bc;
    logic                    s6_valid;
    logic                    s6_last;

`ifdef CAL_MAC_SAT_EN
    logic sat_ac;
    logic sat_bc;
    logic nxt_sat_ac;
    logic nxt_sat_bc;

    // Returns {clamped, sum}. Overflow shows as the two top bits of the
    // one-bit-wider sum disagreeing; the wide sign picks the rail.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                               input logic signed [ACC_W-1:0] y);
        logic [ACC_W:0] s;
        s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction
`endif

    always_comb begin
        nxt_ac = s5_ac;
        nxt_bc = s5_bc;
`ifdef CAL_MAC_SAT_EN
        nxt_sat_ac = 1'b0;
        nxt_sat_bc = 1'b0;
        if (grp_open) begin
            {nxt_sat_ac, nxt_ac} = sat_add(acc_ac, s5_ac);
            {nxt_sat_bc, nxt_bc} = sat_add(acc_bc, s5_bc);
            nxt_sat_ac = nxt_sat_ac | sat_ac;
            nxt_sat_bc = nxt_sat_bc | sat_bc;
        end
`else
        if (grp_open) begin
            nxt_ac = acc_ac + s5_ac;
            nxt_bc = acc_bc + s5_bc;
        end
`endif
    end

    // S6 updates the accumulators; the output register one edge later reads
    // the finished sums while S6 may already be loading the next group.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_open      <= 1'b0;
            acc_ac        <= '0;
            acc_bc        <= '0;
            s6_valid      <= 1'b0;
            s6_last       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_ac    <= '0;
            bus.out_bc    <= '0;
`ifdef CAL_MAC_SAT_EN
            sat_ac        <= 1'b0;
            sat_bc        <= 1'b0;
            bus.out_sat   <= 1'b0;
`endif
        end else begin
            s6_valid <= s5_valid;
            s6_last  <= s5_last;
            if (s5_valid) begin
                acc_ac   <= nxt_ac;
                acc_bc   <= nxt_bc;
                grp_open <= ~s5_last;
`ifdef CAL_MAC_SAT_EN
                sat_ac   <= nxt_sat_ac;
                sat_bc   <= nxt_sat_bc;
`endif
            end
            bus.out_valid <= s6_valid & s6_last;
            if (s6_valid && s6_last) begin
                bus.out_ac  <= acc_ac;
                bus.out_bc  <= acc_bc;
`ifdef CAL_MAC_SAT_EN
                bus.out_sat <= sat_ac | sat_bc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cal_mac_int8_x2_acc.sv
// Bench for cal_mac_int8_x2_acc: two instances (ACC_W=24 and ACC_W=17) fed
// the same samples, checked against a group-sum reference model.
module tb_cal_mac_int8_x2_acc;

    localparam int DW = 8;
    localparam int W0 = 24;
    localparam int W1 = 17;
    localparam int LAT = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    cal_mac_int8_x2_acc_if #(.DATA_W(DW), .ACC_W(W0)) if24 ();
    cal_mac_int8_x2_acc_if #(.DATA_W(DW), .ACC_W(W1)) if17 ();

    cal_mac_int8_x2_acc #(.DATA_W(DW), .ACC_W(W0)) dut24 (
        .clk (clk),
        .rst (rst),
        .bus (if24)
    );

    cal_mac_int8_x2_acc #(.DATA_W(DW), .ACC_W(W1)) dut17 (
        .clk (clk),
        .rst (rst),
        .bus (if17)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic signed [31:0] q24_ac[$];
    logic signed [31:0] q24_bc[$];
    logic signed [31:0] q17_ac[$];
    logic signed [31:0] q17_bc[$];
    int                 qcyc24[$];
    int                 qcyc17[$];
`ifdef CAL_MAC_SAT_EN
    logic               qsat24[$];
    logic               qsat17[$];
`endif

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Group sums computed from plain integer products; one running value per
    // instance width, applying wrap or clamp at every accumulate.
    longint run_ac[2];
    longint run_bc[2];
    bit     flg[2];
    bit     in_grp = 1'b0;

    function automatic int wid(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint clampw(input longint v, input int w, output bit f);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        f  = 1'b0;
        if (v > hi) begin f = 1'b1; return hi; end
        if (v < lo) begin f = 1'b1; return lo; end
        return v;
    endfunction

    task automatic model_sample(input int a, input int b, input int c, input bit last, input int cyc);
        longint pa;
        longint pb;
        bit     fa;
        bit     fb;
        pa = longint'(a * c);
        pb = longint'(b * c);
        for (int k = 0; k < 2; k++) begin
            if (!in_grp) begin
                run_ac[k] = pa;
                run_bc[k] = pb;
                flg[k]    = 1'b0;
            end else begin
`ifdef CAL_MAC_SAT_EN
                run_ac[k] = clampw(run_ac[k] + pa, wid(k), fa);
                run_bc[k] = clampw(run_bc[k] + pb, wid(k), fb);
                flg[k]    = flg[k] | fa | fb;
`else
                fa = 1'b0;
                fb = 1'b0;
                run_ac[k] = wrapw(run_ac[k] + pa, wid(k));
                run_bc[k] = wrapw(run_bc[k] + pb, wid(k));
`endif
            end
        end
        if (last) begin
            q24_ac.push_back(32'(run_ac[0]));
            q24_bc.push_back(32'(run_bc[0]));
            q17_ac.push_back(32'(run_ac[1]));
            q17_bc.push_back(32'(run_bc[1]));
            qcyc24.push_back(cyc + LAT);
            qcyc17.push_back(cyc + LAT);
`ifdef CAL_MAC_SAT_EN
            qsat24.push_back(flg[0]);
            qsat17.push_back(flg[1]);
`endif
        end
        in_grp = !last;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit v, input bit l, input int a, input int b, input int c);
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] cv;
        av = a;
        bv = b;
        cv = c;
        if24.in_valid = v;  if17.in_valid = v;
        if24.in_last  = l;  if17.in_last  = l;
        if24.in_a = av[DW-1:0];  if17.in_a = av[DW-1:0];
        if24.in_b = bv[DW-1:0];  if17.in_b = bv[DW-1:0];
        if24.in_c = cv[DW-1:0];  if17.in_c = cv[DW-1:0];
    endtask

    task automatic drive(input int a, input int b, input int c, input bit last);
        set_in(1'b1, last, a, b, c);
        @(posedge clk);
        #1;
        model_sample(a, b, c, last, edge_cnt);
        set_in(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 1'b0, 0, 0, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_grp = 1'b0;
        q24_ac.delete(); q24_bc.delete(); q17_ac.delete(); q17_bc.delete();
        qcyc24.delete(); qcyc17.delete();
`ifdef CAL_MAC_SAT_EN
        qsat24.delete(); qsat17.delete();
`endif
    endtask

    function automatic int rand8();
        logic [7:0] r;
        case ($urandom_range(0, 7))
            0:       r = 8'h80;
            1:       r = 8'h7f;
            default: r = 8'($urandom_range(0, 255));
        endcase
        return int'($signed(r));
    endfunction

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        if (!rst && if24.out_valid) begin
            if (q24_ac.size() == 0) begin
                check("w24_unexpected_strobe", 1, 0);
            end else begin
                check("w24_ac", if24.out_ac, q24_ac.pop_front());
                check("w24_bc", if24.out_bc, q24_bc.pop_front());
                check("w24_latency", edge_cnt, qcyc24.pop_front());
`ifdef CAL_MAC_SAT_EN
                check("w24_sat", if24.out_sat, qsat24.pop_front());
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if17.out_valid) begin
            if (q17_ac.size() == 0) begin
                check("w17_unexpected_strobe", 1, 0);
            end else begin
                check("w17_ac", if17.out_ac, q17_ac.pop_front());
                check("w17_bc", if17.out_bc, q17_bc.pop_front());
                check("w17_latency", edge_cnt, qcyc17.pop_front());
`ifdef CAL_MAC_SAT_EN
                check("w17_sat", if17.out_sat, qsat17.pop_front());
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        int len;
        set_in(1'b0, 1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        do_reset();

        // Reset state.
        check("rst_valid24", if24.out_valid, 0);
        check("rst_ac24", if24.out_ac, 0);
        check("rst_bc24", if24.out_bc, 0);
        check("rst_valid17", if17.out_valid, 0);
        check("rst_ac17", if17.out_ac, 0);
        check("rst_bc17", if17.out_bc, 0);

        // Single sample, then the strobe must drop after one cycle.
        drive(3, 5, 7, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (if24.out_valid) seen = 1'b1;
        end
        check("t1_strobe_seen", seen, 1);
        @(negedge clk);
        check("t1_strobe_width", if24.out_valid, 0);
        check("t1_ac_hold", if24.out_ac, 21);
        check("t1_bc_hold", if24.out_bc, 35);
        #1;

        // Borrow correction corners.
        drive(1, -1, 1, 1'b1);
        drive(-128, -128, -128, 1'b1);
        drive(127, -128, -128, 1'b1);
        idle(8);

        // Bubbles inside a group.
        drive(100, -100, 100, 1'b0);
        idle(2);
        drive(100, -100, 100, 1'b0);
        idle(1);
        drive(100, -100, 100, 1'b0);
        idle(3);
        drive(100, -100, 100, 1'b1);
        idle(8);

        // Back-to-back groups.
        drive(2, 3, 4, 1'b0);
        drive(2, 3, 4, 1'b1);
        drive(-1, 1, 5, 1'b1);
        idle(8);

        // in_last without in_valid must not close a group.
        drive(1, 2, 3, 1'b0);
        set_in(1'b0, 1'b1, 9, 9, 9);
        @(posedge clk);
        #1;
        drive(4, 5, 6, 1'b1);
        idle(8);

        // Reset mid-group discards the partial sums.
        drive(9, 9, 9, 1'b0);
        drive(9, 9, 9, 1'b0);
        do_reset();
        drive(1, 1, 1, 1'b1);
        idle(10);

        // Overflow: wraps (or clamps) on the 17-bit instance.
        for (int i = 0; i < 10; i++) drive(127, 127, 127, (i == 9));
        for (int i = 0; i < 10; i++) drive(-128, 127, -128, (i == 9));
        idle(8);

        // Random groups with random bubbles.
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 6);
            for (int s = 0; s < len; s++) begin
                drive(rand8(), rand8(), rand8(), (s == len - 1));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 40 && (q24_ac.size() + q17_ac.size()) != 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("drain_w24_left", q24_ac.size(), 0);
        check("drain_w17_left", q17_ac.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
